// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared front-end constants and the fetch state encoding
// Rev 1.0
// ============================================================================
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    FLUSH      = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : small in-order queue with push, pop and a single-cycle flush
// Rev 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_q];

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : credit-limited instruction fetch with redirect flush
// Rev 1.0
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req_valid,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [XLEN-1:0]     imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic [OPCODE_W-1:0] op,
  input  logic                instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]    drop_sum;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  buf_count;
  logic [XLEN-1:0]   rsp_pc;
  logic [2*XLEN-1:0] head;
  logic              pcq_full, pcq_empty;
  logic              buf_full, buf_empty;
  logic              credit_ok;
  logic              accept;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              do_pop;

  // Request pcs wait here until their in-order response returns.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head_data (rsp_pc),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (outstanding)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rsp_keep),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (do_pop),
    .flush     (redirect_valid),
    .head_data (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Never issue more than the buffer can absorb, counting requests still in flight.
  assign credit_ok = !pcq_full && !buf_full &&
                     ((CNT_W+1)'(outstanding) + (CNT_W+1)'(buf_count) < (CNT_W+1)'(DEPTH));

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !pcq_empty && !redirect_valid;
  assign do_pop   = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + {1'b0, outstanding};
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      if (imem_rsp_valid && (drop_sum != '0)) begin
        drop_sum = drop_sum - 1'b1;
      end
      drop_cnt_d = drop_sum[CNT_W-1:0];
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FLUSH is left as soon as no dropped response remains, even under a fresh redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_WAIT: state_d = RUN;
      RUN:        if (redirect_valid && (drop_cnt_d != '0)) state_d = FLUSH;
      FLUSH:      if (drop_cnt_d == '0) state_d = RUN;
      default:    state_d = RESET_WAIT;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == RUN) && !redirect_valid && credit_ok;
    imem_req_addr  = pc_q;
  end

  assign instr_valid = !buf_empty;
  assign instr       = buf_empty ? '0 : head[XLEN-1:0];
  assign instr_pc    = buf_empty ? '0 : head[2*XLEN-1:XLEN];
  assign op          = instr[OPCODE_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit with an in-order memory model
// Rev 1.0
// ============================================================================
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .instr_ready    (instr_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        arrived;
  } sb_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_t;

  sb_t         sb_q[$];
  mem_t        mem_q[$];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          last_due = 0;
  int          mem_lat  = 1;
  int          accepts  = 0;
  bit          in_rw    = 1'b0;
  logic [31:0] exp_pc   = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h003100B3 ^ (a * 32'h9E3779B1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive the memory response, sample mid-cycle, update the model.
  task automatic step();
    int          stale;
    int          pending;
    int          arrived;
    int          due;
    bit          rsp_fresh;
    bit          exp_req;
    bit          exp_iv;
    logic [31:0] a;
    stale     = 0;
    pending   = 0;
    arrived   = 0;
    rsp_fresh = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    foreach (sb_q[i]) if (sb_q[i].arrived) arrived++; else pending++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      rsp_fresh      = (mem_q[0].epoch == epoch);
      void'(mem_q.pop_front());
    end
    #4;
    exp_req = !in_rw && (stale == 0) && !redirect_valid && (pending + arrived < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
    exp_iv = (sb_q.size() > 0) && sb_q[0].arrived;
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("instr_pc", instr_pc, sb_q[0].pc);
      check("instr", instr, sb_q[0].data);
      check("op", 32'(op), 32'(sb_q[0].data[6:0]));
    end
    if (redirect_valid) begin
      sb_q.delete();
      epoch++;
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_iv && instr_ready) void'(sb_q.pop_front());
      if (imem_rsp_valid && rsp_fresh) begin
        for (int i = 0; i < sb_q.size(); i++) begin
          if (!sb_q[i].arrived) begin
            sb_q[i].arrived = 1'b1;
            break;
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        a   = imem_req_addr;
        due = cyc + mem_lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: a, due: due, epoch: epoch});
        sb_q.push_back('{pc: a, data: mem_word(a), arrived: 1'b0});
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    in_rw = 1'b0;
  endtask

  // Memory is reset together with the fetch unit, so all its pending responses vanish.
  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_op", 32'(op), 32'd0);
    mem_q.delete();
    sb_q.delete();
    epoch++;
    exp_pc   = RESET_PC;
    last_due = cyc;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset_n = 1'b1;
    in_rw   = 1'b1;
  endtask

  initial begin
    int guard;
    reset_n        = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    #2;

    // Streaming from reset with single-cycle memory.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_lat        = 1;
    guard          = 0;
    while (!instr_valid && guard < 10) begin
      step();
      guard++;
    end
    check("first_instr_seen", 32'(instr_valid), 32'd1);
    check("first_instr_pc", instr_pc, 32'h0);
    check("first_op", 32'(op), 32'(7'b0110011));
    repeat (12) step();

    // Decode stalled: credit caps in-flight plus buffered at DEPTH.
    do_reset();
    instr_ready = 1'b0;
    accepts     = 0;
    repeat (8) step();
    check("stall_accepts", 32'(accepts), 32'd2);
    check("stall_count", 32'(dut.buf_count), 32'd2);
    instr_ready = 1'b1;
    repeat (10) step();

    // Redirect with two requests in flight.
    do_reset();
    mem_lat = 3;
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("flush_state", 32'(dut.state_q), 32'(FLUSH));
    repeat (12) step();

    // Misaligned redirect while memory is not ready.
    mem_lat        = 1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("misalign_addr", imem_req_addr, 32'h100);
    imem_req_ready = 1'b1;
    repeat (10) step();

    // Address wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    repeat (10) step();

    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      mem_lat        = $urandom_range(1, 3);
      step();
    end
    redirect_valid = 1'b0;

    // Reset pulsed while dropping responses.
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    mem_lat        = 4;
    guard          = 0;
    while (!(dut.state_q == RUN && sb_q.size() > 0 && !sb_q[0].arrived) && guard < 20) begin
      step();
      guard++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("mid_flush_state", 32'(dut.state_q), 32'(FLUSH));
    do_reset();
    guard = 0;
    while (!imem_req_valid && guard < 10) begin
      step();
      guard++;
    end
    check("post_reset_req", 32'(imem_req_valid), 32'd1);
    check("post_reset_addr", imem_req_addr, RESET_PC);
    instr_ready = 1'b1;
    repeat (15) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
